// File: rtl/udp_buf_pkg.sv
// Shared types and constants for the UDP payload buffer: controller states,
// default-message lengths and the fixed greeting text.
package udp_buf_pkg;

    typedef enum logic [0:0] {
        ST_PRELOAD = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam logic [15:0] DEF_DATA_LEN_C  = 16'd28;
    localparam logic [15:0] DEF_TOTAL_LEN_C = 16'd48;

    // "HELLO QMTECH BOARD\n\r", first character in the most significant byte
    localparam int MSG_LEN_C = 5;
    localparam logic [31:0] DEF_MSG_C [0:MSG_LEN_C-1] = '{
        32'h48454C4C, 32'h4F20514D, 32'h54454348, 32'h20424F41, 32'h52440A0D
    };

endpackage

// File: rtl/udp_msg_rom.sv
// Combinational ROM holding the default message; indices past its end read zero.
module udp_msg_rom
    import udp_buf_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      word
);

    // Match the index against each stored word
    always_comb begin
        word = 32'h0000_0000;
        for (int i = 0; i < MSG_LEN_C; i++) begin
            word = (idx == IDX_W'(i)) ? DEF_MSG_C[i] : word;
        end
    end

endmodule

// File: rtl/udp_payload_buf.sv
// Multi-bank payload buffer between a GMII receiver and a UDP transmitter:
// bank 0 holds a fixed message, banks 1..NUM_BANKS hold looped-back packets.
module udp_payload_buf
    import udp_buf_pkg::*;
#(
    parameter int          DATA_W        = 32,
    parameter int          ADDR_W        = 9,
    parameter int          NUM_BANKS     = 2,
    parameter int          MSG_WORDS     = 5,
    parameter logic [15:0] DEF_DATA_LEN  = DEF_DATA_LEN_C,
    parameter logic [15:0] DEF_TOTAL_LEN = DEF_TOTAL_LEN_C
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              rx_wr_en,
    input  logic [ADDR_W-1:0] rx_wr_addr,
    input  logic [DATA_W-1:0] rx_wr_data,
    input  logic              rx_pkt_done,
    input  logic [15:0]       rx_data_length,
    input  logic [15:0]       rx_total_length,
    input  logic              tx_pkt_start,
    input  logic              tx_pkt_done,
    input  logic [ADDR_W-1:0] tx_rd_addr,
    output logic [DATA_W-1:0] tx_rd_data,
    output logic [15:0]       tx_data_length,
    output logic [15:0]       tx_total_length,
    output logic              tx_ready,
    output logic              preload_done,
    output logic [15:0]       drop_cnt
);

    localparam int BANK_W = $clog2(NUM_BANKS + 1);
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);
    localparam int K_W    = ADDR_W + 1;
    localparam int DEPTH  = (NUM_BANKS + 1) << ADDR_W;

    state_t             state_r;
    logic [K_W-1:0]     k_r;
    logic [NUM_BANKS:1] full_r;
    logic [BANK_W-1:0]  fifo_r [0:NUM_BANKS-1];
    logic [CNT_W-1:0]   fifo_cnt_r;
    logic [15:0]        len_data_r  [1:NUM_BANKS];
    logic [15:0]        len_total_r [1:NUM_BANKS];
    logic               sel_valid_r;
    logic [BANK_W-1:0]  sel_bank_r;
    logic               rx_active_r;
    logic               rx_mode_r;
    logic [DATA_W-1:0]  mem_r [0:DEPTH-1];

    logic [31:0]              rom_word_s;
    logic [BANK_W-1:0]        wr_bank_s;
    logic                     have_bank_s;
    logic [15:0]              head_data_len_s;
    logic [15:0]              head_total_len_s;
    logic [CNT_W-1:0]         push_idx_s;
    logic                     ram_we_s;
    logic [BANK_W+ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0]        ram_wdata_s;

    udp_msg_rom #(.IDX_W(K_W)) u_rom (
        .idx  (k_r),
        .word (rom_word_s)
    );

    // A packet keeps the mode seen at its first word, so toggling mode mid-packet has no effect
    wire run_s      = (state_r == ST_RUN);
    wire eff_mode_s = rx_active_r ? rx_mode_r : mode;
    wire rx_wr_s    = run_s && rx_wr_en && eff_mode_s && have_bank_s;
    wire rx_done_s  = run_s && rx_pkt_done && eff_mode_s;
    wire push_s     = rx_done_s && have_bank_s;
    wire drop_s     = rx_done_s && !have_bank_s;
    wire start_s    = run_s && tx_pkt_start && !sel_valid_r;
    wire take_s     = mode && (fifo_cnt_r != {CNT_W{1'b0}});
    wire done_s     = run_s && tx_pkt_done && sel_valid_r;
    wire pop_s      = done_s && (sel_bank_r != {BANK_W{1'b0}});

    assign tx_ready = preload_done;

    // Lowest-numbered free receive bank and FIFO head lengths
    always_comb begin
        wr_bank_s        = {BANK_W{1'b0}};
        have_bank_s      = 1'b0;
        head_data_len_s  = 16'h0000;
        head_total_len_s = 16'h0000;
        for (int b = NUM_BANKS; b >= 1; b--) begin
            have_bank_s = have_bank_s | ~full_r[b];
            wr_bank_s   = full_r[b] ? wr_bank_s : BANK_W'(b);
        end
        for (int b = 1; b <= NUM_BANKS; b++) begin
            head_data_len_s  = (fifo_r[0] == BANK_W'(b)) ? len_data_r[b]  : head_data_len_s;
            head_total_len_s = (fifo_r[0] == BANK_W'(b)) ? len_total_r[b] : head_total_len_s;
        end
    end

    // RAM write port: preload feeds bank 0, afterwards the receiver owns it
    always_comb begin
        if (pop_s) begin
            push_idx_s = fifo_cnt_r - CNT_W'(1);
        end else begin
            push_idx_s = fifo_cnt_r;
        end
        if (state_r == ST_PRELOAD) begin
            ram_we_s    = reset_n && (k_r < K_W'(MSG_WORDS));
            ram_waddr_s = {{BANK_W{1'b0}}, k_r[ADDR_W-1:0]};
            ram_wdata_s = DATA_W'(rom_word_s);
        end else begin
            ram_we_s    = reset_n && rx_wr_s;
            ram_waddr_s = {wr_bank_s, rx_wr_addr};
            ram_wdata_s = rx_wr_data;
        end
    end

    // Bank memory write port
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Registered read of the selected bank
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_rd_data <= {DATA_W{1'b0}};
        end else begin
            tx_rd_data <= mem_r[{sel_bank_r, tx_rd_addr}];
        end
    end

    // Preload controller: k walks one step past the message so done lands a cycle later
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_PRELOAD;
            k_r          <= {K_W{1'b0}};
            preload_done <= 1'b0;
        end else begin
            case (state_r)
                ST_PRELOAD: begin
                    if (k_r == K_W'(MSG_WORDS)) begin
                        state_r      <= ST_RUN;
                        preload_done <= 1'b1;
                    end else begin
                        k_r <= k_r + K_W'(1);
                    end
                end
                ST_RUN:  preload_done <= 1'b1;
                default: state_r <= ST_PRELOAD;
            endcase
        end
    end

    // Bank occupancy, arrival-ordered FIFO, packet mode latch and drop counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_r      <= {NUM_BANKS{1'b0}};
            fifo_cnt_r  <= {CNT_W{1'b0}};
            rx_active_r <= 1'b0;
            rx_mode_r   <= 1'b0;
            drop_cnt    <= 16'h0000;
            for (int i = 0; i < NUM_BANKS; i++) begin
                fifo_r[i] <= {BANK_W{1'b0}};
            end
        end else begin
            for (int b = 1; b <= NUM_BANKS; b++) begin
                if (push_s && wr_bank_s == BANK_W'(b)) begin
                    full_r[b] <= 1'b1;
                end else if (pop_s && sel_bank_r == BANK_W'(b)) begin
                    full_r[b] <= 1'b0;
                end
            end
            for (int i = 0; i < NUM_BANKS - 1; i++) begin
                if (pop_s) begin
                    fifo_r[i] <= fifo_r[i+1];
                end
            end
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (push_s && push_idx_s == CNT_W'(i)) begin
                    fifo_r[i] <= wr_bank_s;
                end
            end
            fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
            if (run_s && rx_pkt_done) begin
                rx_active_r <= 1'b0;
            end else if (run_s && rx_wr_en && !rx_active_r) begin
                rx_active_r <= 1'b1;
                rx_mode_r   <= mode;
            end
            if (drop_s && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Lengths captured for each receive bank as it closes
    always_ff @(posedge clk) begin
        for (int b = 1; b <= NUM_BANKS; b++) begin
            if (push_s && wr_bank_s == BANK_W'(b)) begin
                len_data_r[b]  <= rx_data_length;
                len_total_r[b] <= rx_total_length;
            end
        end
    end

    // Transmit selection held from start until done
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_valid_r     <= 1'b0;
            sel_bank_r      <= {BANK_W{1'b0}};
            tx_data_length  <= 16'h0000;
            tx_total_length <= 16'h0000;
        end else if (start_s) begin
            sel_valid_r <= 1'b1;
            if (take_s) begin
                sel_bank_r      <= fifo_r[0];
                tx_data_length  <= head_data_len_s;
                tx_total_length <= head_total_len_s;
            end else begin
                sel_bank_r      <= {BANK_W{1'b0}};
                tx_data_length  <= DEF_DATA_LEN;
                tx_total_length <= DEF_TOTAL_LEN;
            end
        end else if (done_s) begin
            sel_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udp_payload_buf.sv
// Self-checking bench for udp_payload_buf: directed corner sequences plus
// random packet traffic against a queue-based model of the bank FIFO.
module tb_udp_payload_buf;

    localparam int NB = 2;

    logic        clk = 1'b0;
    logic        reset_n, mode, rx_wr_en, rx_pkt_done, tx_pkt_start, tx_pkt_done;
    logic [8:0]  rx_wr_addr, tx_rd_addr;
    logic [31:0] rx_wr_data, tx_rd_data;
    logic [15:0] rx_data_length, rx_total_length, tx_data_length, tx_total_length, drop_cnt;
    logic        tx_ready, preload_done;

    always #5 clk = ~clk;

    udp_payload_buf dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .rx_wr_en(rx_wr_en), .rx_wr_addr(rx_wr_addr), .rx_wr_data(rx_wr_data),
        .rx_pkt_done(rx_pkt_done), .rx_data_length(rx_data_length),
        .rx_total_length(rx_total_length),
        .tx_pkt_start(tx_pkt_start), .tx_pkt_done(tx_pkt_done), .tx_rd_addr(tx_rd_addr),
        .tx_rd_data(tx_rd_data), .tx_data_length(tx_data_length),
        .tx_total_length(tx_total_length), .tx_ready(tx_ready),
        .preload_done(preload_done), .drop_cnt(drop_cnt)
    );

    typedef struct {
        int               n;
        logic [15:0]      dl;
        logic [15:0]      tl;
        logic [15:0][31:0] w;
    } pkt_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] exp;
    } vec_t;

    pkt_t mq[$];
    pkt_t def_pkt, cur, p1, p2, p3, p4;
    bit   cur_from_fifo;
    int   model_drop;
    int   n_checks, n_fail;
    vec_t tbl [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rx_wr_en = 0; rx_wr_addr = '0; rx_wr_data = '0; rx_pkt_done = 0;
        rx_data_length = '0; rx_total_length = '0;
        tx_pkt_start = 0; tx_pkt_done = 0; tx_rd_addr = '0;
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.n  = $urandom_range(1, 8);
        p.dl = 16'($urandom);
        p.tl = 16'($urandom);
        p.w  = '0;
        for (int i = 0; i < p.n; i++) p.w[i] = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        int cyc;
        reset_n = 0;
        idle();
        step();
        step();
        chk("rst preload_done", 32'(preload_done), 32'd0);
        chk("rst tx_ready", 32'(tx_ready), 32'd0);
        chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst tx_data_length", 32'(tx_data_length), 32'd0);
        chk("rst tx_total_length", 32'(tx_total_length), 32'd0);
        chk("rst tx_rd_data", tx_rd_data, 32'd0);
        mq.delete();
        model_drop = 0;
        cur_from_fifo = 0;
        reset_n = 1;
        cyc = 0;
        while (!preload_done && cyc < 20) begin
            step();
            cyc++;
        end
        chk("preload latency", 32'(cyc), 32'd6);
    endtask

    task automatic rx_words(input pkt_t p, input int upto);
        for (int i = 0; i < upto; i++) begin
            rx_wr_en = 1; rx_wr_addr = 9'(i); rx_wr_data = p.w[i];
            step();
        end
        rx_wr_en = 0;
    endtask

    // Closes a packet; the model decides acceptance before any simultaneous free
    task automatic rx_done(input pkt_t p, input bit with_tx_done);
        rx_pkt_done = 1; rx_data_length = p.dl; rx_total_length = p.tl;
        tx_pkt_done = with_tx_done;
        if (mode) begin
            if (mq.size() < NB) mq.push_back(p);
            else if (model_drop < 65535) model_drop++;
        end
        if (with_tx_done && cur_from_fifo) void'(mq.pop_front());
        if (with_tx_done) cur_from_fifo = 0;
        step();
        rx_pkt_done = 0; tx_pkt_done = 0;
        chk("drop_cnt", 32'(drop_cnt), 32'(model_drop));
    endtask

    task automatic tx_open();
        if (mode && mq.size() > 0) begin
            cur = mq[0];
            cur_from_fifo = 1;
        end else begin
            cur = def_pkt;
            cur_from_fifo = 0;
        end
        tx_pkt_start = 1;
        step();
        tx_pkt_start = 0;
        chk("tx_data_length", 32'(tx_data_length), 32'(cur.dl));
        chk("tx_total_length", 32'(tx_total_length), 32'(cur.tl));
        for (int i = 0; i < cur.n; i++) begin
            tx_rd_addr = 9'(i);
            step();
            chk("tx_rd_data", tx_rd_data, cur.w[i]);
        end
    endtask

    task automatic tx_close();
        tx_pkt_done = 1;
        step();
        tx_pkt_done = 0;
        if (cur_from_fifo) void'(mq.pop_front());
        cur_from_fifo = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; model_drop = 0; cur_from_fifo = 0;
        mode = 0;
        def_pkt.n = 5; def_pkt.dl = 16'd28; def_pkt.tl = 16'd48; def_pkt.w = '0;
        def_pkt.w[0] = 32'h48454C4C; def_pkt.w[1] = 32'h4F20514D; def_pkt.w[2] = 32'h54454348;
        def_pkt.w[3] = 32'h20424F41; def_pkt.w[4] = 32'h52440A0D;
        tbl[0] = '{9'd0, 32'h48454C4C};
        tbl[1] = '{9'd1, 32'h4F20514D};
        tbl[2] = '{9'd2, 32'h54454348};
        tbl[3] = '{9'd3, 32'h20424F41};
        tbl[4] = '{9'd4, 32'h52440A0D};

        // Default message after reset, table driven
        do_reset();
        chk("tx_ready", 32'(tx_ready), 32'd1);
        tx_pkt_start = 1;
        step();
        tx_pkt_start = 0;
        chk("def data_length", 32'(tx_data_length), 32'd28);
        chk("def total_length", 32'(tx_total_length), 32'd48);
        for (int i = 0; i < 5; i++) begin
            tx_rd_addr = tbl[i].addr;
            step();
            chk("def word", tx_rd_data, tbl[i].exp);
        end
        tx_close();

        // Loopback of one packet, then back to the default message
        mode = 1;
        p1.n = 3; p1.dl = 16'd12; p1.tl = 16'd32; p1.w = '0;
        p1.w[0] = 32'd1; p1.w[1] = 32'd2; p1.w[2] = 32'd3;
        rx_words(p1, p1.n); rx_done(p1, 0);
        tx_open(); tx_close();
        tx_open(); tx_close();

        // Overflow: third packet dropped; stray done and repeated start ignored
        p1 = rand_pkt(); p2 = rand_pkt(); p3 = rand_pkt();
        rx_words(p1, p1.n); rx_done(p1, 0);
        tx_pkt_done = 1; step(); tx_pkt_done = 0;
        rx_words(p2, p2.n); rx_done(p2, 0);
        rx_words(p3, p3.n); rx_done(p3, 0);
        chk("drop after overflow", 32'(drop_cnt), 32'd1);
        tx_open();
        tx_pkt_start = 1; step(); tx_pkt_start = 0;
        chk("restart ignored dl", 32'(tx_data_length), 32'(p1.dl));
        tx_rd_addr = 9'd0; step();
        chk("restart ignored word", tx_rd_data, p1.w[0]);
        tx_close();
        tx_open(); tx_close();
        tx_open(); tx_close();

        // Full banks with simultaneous rx and tx done
        p1 = rand_pkt(); p2 = rand_pkt(); p3 = rand_pkt(); p4 = rand_pkt();
        rx_words(p1, p1.n); rx_done(p1, 0);
        rx_words(p2, p2.n); rx_done(p2, 0);
        tx_open();
        rx_words(p3, p3.n); rx_done(p3, 1);
        chk("drop on simultaneous", 32'(drop_cnt), 32'd2);
        rx_words(p4, p4.n); rx_done(p4, 0);
        tx_open(); tx_close();
        tx_open(); tx_close();
        tx_open(); tx_close();

        // Reset mid-receive, then mid-transmit
        p1 = rand_pkt(); p2 = rand_pkt();
        rx_words(p1, p1.n); rx_done(p1, 0);
        rx_words(p2, 1);
        do_reset();
        tx_open(); tx_close();
        rx_words(p2, p2.n); rx_done(p2, 0);
        tx_open();
        do_reset();
        tx_open(); tx_close();

        // Fixed-message mode ignores receive traffic
        mode = 0;
        for (int i = 0; i < 3; i++) begin
            p1 = rand_pkt();
            rx_words(p1, p1.n); rx_done(p1, 0);
        end
        chk("mode0 drop_cnt", 32'(drop_cnt), 32'd0);
        tx_open(); tx_close();
        tx_open(); tx_close();

        // Random traffic against the model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                p1 = rand_pkt();
                rx_words(p1, p1.n); rx_done(p1, 0);
            end else begin
                tx_open(); tx_close();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_payload_buf.md
UDP_PAYLOAD_BUF -- requirements
Module: udp_payload_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9: word address width per bank.
REQ-003 SHALL have parameter NUM_BANKS, default 2: number of receive banks, legal range 2..4.
REQ-004 SHALL have parameter MSG_WORDS, default 5: default-message length in words, at most 2**ADDR_W.
REQ-005 SHALL have parameter DEF_DATA_LEN, default 28, and DEF_TOTAL_LEN, default 48: UDP and IP lengths used for the default message.
REQ-006 SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock for receive and transmit (the 125 MHz GMII rx clock).
  reset_n  in  1  reset; synchronous, active-low.
  mode  in  1  0 = fixed message only; 1 = loopback of received packets.
  rx_wr_en  in  1  receive word valid.
  rx_wr_addr  in  ADDR_W  word offset within the current packet.
  rx_wr_data  in  DATA_W  received word.
  rx_pkt_done  in  1  one-cycle pulse marking the end of a good packet.
  rx_data_length, rx_total_length  in  16 each  lengths of the packet that rx_pkt_done closes.
  tx_pkt_start  in  1  pulse: transmitter begins a packet.
  tx_pkt_done  in  1  pulse: transmitter has finished the packet.
  tx_rd_addr  in  ADDR_W  read word offset.
  tx_rd_data  out  DATA_W  read data.
  tx_data_length, tx_total_length  out  16 each  lengths of the selected packet.
  tx_ready  out  1  a packet is available to send.
  preload_done  out  1  default message has been written.
  drop_cnt  out  16  count of dropped received packets.

Function
REQ-007 SHALL hold NUM_BANKS+1 banks of 2**ADDR_W words: bank 0 holds the default message; banks 1..NUM_BANKS hold received packets.
REQ-008 SHALL run a state machine PRELOAD -> RUN. PRELOAD SHALL write message word k to bank 0 at offset k, one word per cycle for k = 0..MSG_WORDS-1, then SHALL enter RUN and set preload_done = 1.
REQ-009 SHALL ignore rx_wr_en, rx_pkt_done, tx_pkt_start and tx_pkt_done while in PRELOAD.
REQ-010 In RUN with mode = 1, rx_wr_en SHALL write rx_wr_data to the current write bank at rx_wr_addr.
REQ-011 If mode = 0, all receive inputs SHALL be ignored.
REQ-012 The current write bank SHALL be the lowest-numbered free receive bank. If no receive bank is free, writes SHALL be discarded and the packet is dropped.
REQ-013 On rx_pkt_done when a write bank exists, the block SHALL mark that bank full, latch both rx lengths for it, and append it to a FIFO of full banks (depth NUM_BANKS, ordered by arrival).
REQ-014 On rx_pkt_done when no bank is free, drop_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-015 tx_ready SHALL equal preload_done.
REQ-016 On tx_pkt_start, the block SHALL select the FIFO head bank when mode = 1 and the FIFO is non-empty; otherwise it SHALL select bank 0.
REQ-017 The selected bank and its lengths SHALL be held until tx_pkt_done.
REQ-018 Bank 0 SHALL report DEF_DATA_LEN and DEF_TOTAL_LEN as its lengths.
REQ-019 tx_rd_data SHALL equal the word at tx_rd_addr in the selected bank, registered with a latency of exactly 1 cycle.
REQ-020 tx_data_length and tx_total_length SHALL be valid from the cycle after tx_pkt_start.
REQ-021 On tx_pkt_done, a selected receive bank SHALL be popped from the FIFO and freed; a selected bank 0 SHALL not be freed.
REQ-022 A tx_pkt_start while a packet is already selected SHALL be ignored.
REQ-023 A tx_pkt_done with nothing selected SHALL be ignored.
REQ-024 If rx_pkt_done and tx_pkt_done occur in the same cycle, both SHALL take effect; the freed bank SHALL be usable from the next cycle.
REQ-025 Toggling mode SHALL affect only packets started after the change.

Reset
REQ-026 While reset_n = 0 at a clock edge, the block SHALL set: state = PRELOAD, k = 0, all banks free, FIFO empty, no bank selected, preload_done = 0, drop_cnt = 0, tx_data_length = 0, tx_total_length = 0, tx_rd_data = 0.
REQ-027 A reset asserted mid-operation SHALL abandon any packet being received or transmitted and SHALL restart preload. Memory contents need not be cleared.

Structure
REQ-028 A shared package udp_buf_pkg SHALL hold the state enumeration, the default lengths, and the default message "HELLO QMTECH BOARD\n\r" (5 x 32-bit words).
REQ-029 The default message SHALL come from one sub-module udp_msg_rom: a combinational ROM indexed by k.
REQ-030 The banks SHALL be implemented as one simple dual-port RAM inferred inside the block.

Verification
REQ-031 Release reset: preload_done SHALL rise 6 cycles later. Then tx_pkt_start and reads at addresses 0..4 SHALL return 48454C4C, 4F20514D, 54454348, 20424F41, 52440A0D, with lengths 28/48.
REQ-032 mode = 1, receive packet A (lengths 12/32, words 1..3), then tx_pkt_start: reads SHALL return A's words and lengths 12/32. A tx_pkt_start after tx_pkt_done SHALL return the default message.
REQ-033 mode = 1, receive 3 packets with NUM_BANKS = 2 and no tx activity: the third SHALL be dropped, drop_cnt = 1, and two transmits SHALL return packets 1 then 2 in order.
REQ-034 Banks full; rx_pkt_done and tx_pkt_done in the same cycle: the new packet SHALL be dropped, drop_cnt SHALL increment, and the next packet SHALL be accepted into the freed bank.
REQ-035 Assert reset mid-receive and mid-transmit: all outputs SHALL return to reset values, preload SHALL repeat, and the FIFO SHALL be empty afterwards.
REQ-036 mode = 0 with rx traffic: no bank SHALL fill, drop_cnt SHALL stay 0, and every transmit SHALL return the default message.
